// File: rtl/accumulator_cpu_core_if.sv
// accumulator_cpu_core_if: ready-qualified single-port memory request bus
interface accumulator_cpu_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic                  mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/accumulator_cpu_core.sv
// accumulator_cpu_core: FSM-sequenced accumulator CPU on a ready-qualified memory bus
module accumulator_cpu_core #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 14,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
    parameter int                    PC_STEP    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    accumulator_cpu_core_if.master  mem,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic [DATA_WIDTH-1:0]   acc_o,
    output logic [DATA_WIDTH-1:0]   ir_o,
    output logic                    carry_o,
    output logic                    halt_o,
    output logic                    illegal_o
);
    localparam int OPW = DATA_WIDTH - 4;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, HALTED} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, ir_q, ir_d, mbr_q, mbr_d;
    logic                  carry_q, carry_d, illegal_q, illegal_d;

    logic [3:0]            op;
    logic [OPW-1:0]        x;
    logic [ADDR_WIDTH-1:0] x_addr, pc_inc;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH:0]   sum, diff;
    logic                  acc_neg, acc_zero, skip, is_store;

    assign op       = ir_q[DATA_WIDTH-1 -: 4];
    assign x        = ir_q[OPW-1:0];
    assign x_addr   = ADDR_WIDTH'(x);
    assign pc_inc   = pc_q + ADDR_WIDTH'(PC_STEP);
    // Immediate ops execute in DECODE, memory ops in EXEC with the captured word
    assign operand  = (state_q == EXEC) ? mbr_q : DATA_WIDTH'(x);
    assign sum      = {1'b0, acc_q} + {1'b0, operand};
    assign diff     = {1'b0, acc_q} - {1'b0, operand};
    assign acc_neg  = acc_q[DATA_WIDTH-1];
    assign acc_zero = (acc_q == '0);
    assign skip     = (x[OPW-1:OPW-2] == 2'b00) ? acc_neg :
                      (x[OPW-1:OPW-2] == 2'b01) ? acc_zero :
                      (x[OPW-1:OPW-2] == 2'b10) ? (!acc_neg && !acc_zero) : 1'b0;
    assign is_store = (op == 4'h2);

    // Sequencing, execution and bus drive; a stalled access leaves every register untouched
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        acc_d         = acc_q;
        ir_d          = ir_q;
        mbr_d         = mbr_q;
        carry_d       = carry_q;
        illegal_d     = illegal_q;
        mem.mem_cs    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_oe    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_q)
            IDLE: if (start_i) state_d = FETCH;
            FETCH: begin
                mem.mem_cs   = 1'b1;
                mem.mem_oe   = 1'b1;
                mem.mem_addr = pc_q;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_inc;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = FETCH;
                case (op)
                    4'h0, 4'h1, 4'h2, 4'h3: state_d = MEM;
                    4'h4: state_d = HALTED;
                    4'h5: if (skip) pc_d = pc_inc;
                    4'h6: pc_d = x_addr;
                    4'h7: acc_d = '0;
                    4'h8: begin
                        acc_d   = sum[DATA_WIDTH-1:0];
                        carry_d = sum[DATA_WIDTH];
                    end
                    4'h9: begin
                        acc_d   = diff[DATA_WIDTH-1:0];
                        carry_d = ~diff[DATA_WIDTH];
                    end
                    4'hA: acc_d = acc_q & operand;
                    4'hB: acc_d = acc_q + DATA_WIDTH'(1);
                    4'hC: acc_d = acc_q - DATA_WIDTH'(1);
                    default: begin
                        state_d   = HALTED;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM: begin
                mem.mem_cs    = 1'b1;
                mem.mem_addr  = x_addr;
                mem.mem_we    = is_store;
                mem.mem_oe    = !is_store;
                mem.mem_wdata = is_store ? acc_q : '0;
                if (mem.mem_ready) begin
                    mbr_d   = is_store ? mbr_q : mem.mem_rdata;
                    state_d = is_store ? FETCH : EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (op)
                    4'h0: begin
                        acc_d   = sum[DATA_WIDTH-1:0];
                        carry_d = sum[DATA_WIDTH];
                    end
                    4'h1: acc_d = mbr_q;
                    4'h3: begin
                        acc_d   = diff[DATA_WIDTH-1:0];
                        carry_d = ~diff[DATA_WIDTH];
                    end
                    default: ;
                endcase
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset that also silences the bus immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            acc_q     <= '0;
            ir_q      <= '0;
            mbr_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ir_q      <= ir_d;
            mbr_q     <= mbr_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc_o      = pc_q;
    assign acc_o     = acc_q;
    assign ir_o      = ir_q;
    assign carry_o   = carry_q;
    assign halt_o    = (state_q == HALTED);
    assign illegal_o = illegal_q;
endmodule

// File: tb/tb_accumulator_cpu_core.sv
// tb_accumulator_cpu_core: vector table, directed sequences and random programs vs an instruction-level model
module tb_accumulator_cpu_core;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int MW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc, ir;
    logic          carry, halt, illegal;

    accumulator_cpu_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    accumulator_cpu_core #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(14'h100), .PC_STEP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mem(bus),
        .pc_o(pc), .acc_o(acc), .ir_o(ir), .carry_o(carry),
        .halt_o(halt), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MW];
    logic [DW-1:0] img [MW];
    logic [DW-1:0] rm  [MW];
    logic          clr = 1'b0, ld_en = 1'b0, noise = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    int            wait_n = 0, wcnt = 0;
    int            passed = 0, total = 0;

    // RAM model: each access waits wait_n cycles; ready is random noise while cs is low
    assign bus.mem_ready = bus.mem_cs ? (wcnt >= wait_n) : noise;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        noise <= 1'($urandom_range(0, 1));
        wcnt  <= (bus.mem_cs && !bus.mem_ready) ? wcnt + 1 : 0;
        if (clr) for (int i = 0; i < MW; i++) mem[i] <= '0;
        else if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.mem_cs && bus.mem_we && bus.mem_ready) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [63:0] snap();
        return 64'({bus.mem_addr, bus.mem_wdata, bus.mem_cs, bus.mem_we, bus.mem_oe});
    endfunction

    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        for (int i = 0; i < MW; i++) img[i] = '0;
    endtask

    task automatic poke(input int a, input int d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = DW'(d);
        @(negedge clk) ld_en = 1'b0;
        img[a] = DW'(d);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Pulse start and count cycles: the start cycle is 1, the first cycle with halt high ends the count
    task automatic run(input bit stab, output int cyc);
        logic [63:0] pb;
        bit pw;
        @(negedge clk);
        start = 1'b1; cyc = 1; pw = 1'b0; pb = '0;
        while (!halt && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (stab && pw) chk("bus_stable_in_wait", snap(), pb);
            pw = bus.mem_cs && !bus.mem_ready;
            pb = snap();
        end
        start = 1'b0;
        chk("halt_reached", 64'(halt), 64'd1);
    endtask

    // Instruction-level reference: architectural effect plus cycle cost per instruction
    task automatic model(input int waits, output int e_acc, output int e_c, output int e_pc,
                         output int e_ill, output int e_cyc);
        int a, c, p, cy, w, op, x, v, s, sel, steps;
        bit done;
        for (int i = 0; i < MW; i++) rm[i] = img[i];
        a = 0; c = 0; p = 'h100; cy = 2; steps = 0; done = 0; e_ill = 0;
        while (!done && steps < 400) begin
            steps++;
            w = int'(rm[p]); p = (p + 2) % MW; op = w >> 12; x = w & 'hFFF;
            cy += 2 + waits;
            case (op)
                0: begin v = int'(rm[x]); cy += 2 + waits; a = a + v; c = int'(a > 65535); a = a % 65536; end
                1: begin a = int'(rm[x]); cy += 2 + waits; end
                2: begin rm[x] = DW'(a); cy += 1 + waits; end
                3: begin v = int'(rm[x]); cy += 2 + waits; c = int'(a >= v); a = (a - v + 65536) % 65536; end
                4: done = 1;
                5: begin
                    s = (a >= 32768) ? a - 65536 : a;
                    sel = x >> 10;
                    if ((sel == 0 && s < 0) || (sel == 1 && s == 0) || (sel == 2 && s > 0)) p = (p + 2) % MW;
                end
                6: p = x;
                7: a = 0;
                8: begin a = a + x; c = int'(a > 65535); a = a % 65536; end
                9: begin c = int'(a >= x); a = (a - x + 65536) % 65536; end
                10: a = a & x;
                11: a = (a + 1) % 65536;
                12: a = (a + 65535) % 65536;
                default: begin done = 1; e_ill = 1; end
            endcase
        end
        e_acc = a; e_c = c; e_pc = p; e_cyc = cy;
    endtask

    task automatic load_demo();
        poke('h100, 'h1122); poke('h102, 'h8003); poke('h104, 'h2124);
        poke('h106, 'h4000); poke('h122, 'h0005);
    endtask

    typedef struct {
        logic [15:0] i1, i2, m0, m2, e_acc;
        logic        e_c;
        logic [13:0] e_pc;
    } vec_t;

    vec_t tbl [9];
    int   cyc, e_acc, e_c, e_pc, e_ill, e_cyc, n, bad, op, x;
    bit   seen;

    initial begin
        tbl[0] = '{16'h5400, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 14'h108};
        tbl[1] = '{16'h5400, 16'h4000, 16'h0001, 16'h0000, 16'h0001, 1'b0, 14'h106};
        tbl[2] = '{16'h5000, 16'h4000, 16'h8000, 16'h0000, 16'h8000, 1'b0, 14'h108};
        tbl[3] = '{16'h5800, 16'h4000, 16'h0001, 16'h0000, 16'h0001, 1'b0, 14'h108};
        tbl[4] = '{16'h5C00, 16'h4000, 16'h0001, 16'h0000, 16'h0001, 1'b0, 14'h106};
        tbl[5] = '{16'h8001, 16'h4000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 14'h106};
        tbl[6] = '{16'h9001, 16'h4000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 14'h106};
        tbl[7] = '{16'h3202, 16'hB000, 16'h0005, 16'h0003, 16'h0003, 1'b1, 14'h108};
        tbl[8] = '{16'h8001, 16'hC000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 14'h108};

        #2 rst_n = 1'b0;
        #2;
        chk("rst_pc", 64'(pc), 64'h100);
        chk("rst_acc", 64'(acc), 64'h0);
        chk("rst_ir", 64'(ir), 64'h0);
        chk("rst_flags", 64'({carry, halt, illegal}), 64'h0);
        chk("rst_bus", snap(), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        clear_mem(); load_demo(); wait_n = 0; do_reset();
        run(1'b0, cyc);
        chk("demo_cycles", 64'(cyc), 64'd13);
        chk("demo_store", 64'(mem['h124]), 64'h8);
        chk("demo_acc", 64'(acc), 64'h8);
        chk("demo_pc", 64'(pc), 64'h108);
        chk("demo_halt", 64'(halt), 64'd1);

        wait_n = 3; do_reset();
        model(3, e_acc, e_c, e_pc, e_ill, e_cyc);
        run(1'b1, cyc);
        chk("wait_cycles", 64'(cyc), 64'(e_cyc));
        chk("wait_store", 64'(mem['h124]), 64'h8);
        chk("wait_acc", 64'(acc), 64'h8);
        chk("wait_pc", 64'(pc), 64'h108);

        wait_n = 0;
        for (int i = 0; i < 9; i++) begin
            clear_mem();
            poke('h100, 'h1200); poke('h102, int'(tbl[i].i1)); poke('h104, int'(tbl[i].i2));
            poke('h106, 'h4000); poke('h200, int'(tbl[i].m0)); poke('h202, int'(tbl[i].m2));
            do_reset();
            run(1'b0, cyc);
            chk($sformatf("vec%0d_acc", i), 64'(acc), 64'(tbl[i].e_acc));
            chk($sformatf("vec%0d_carry", i), 64'(carry), 64'(tbl[i].e_c));
            chk($sformatf("vec%0d_pc", i), 64'(pc), 64'(tbl[i].e_pc));
            chk($sformatf("vec%0d_illegal", i), 64'(illegal), 64'd0);
        end

        clear_mem(); poke('h100, 'hD000); do_reset();
        run(1'b0, cyc);
        chk("ill_halt", 64'(halt), 64'd1);
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_pc", 64'(pc), 64'h102);
        seen = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) start = 1'b0;
            seen = seen | bus.mem_cs;
        end
        chk("ill_no_access_after_start", 64'(seen), 64'd0);
        chk("ill_still_halted", 64'(halt), 64'd1);

        clear_mem(); load_demo(); wait_n = 3; do_reset();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(bus.mem_cs && bus.mem_we && !bus.mem_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_store_wait_seen", 64'(bus.mem_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cs_we", 64'({bus.mem_cs, bus.mem_we}), 64'd0);
        chk("rst_async_pc", 64'(pc), 64'h100);
        chk("rst_async_acc", 64'(acc), 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_target_unchanged", 64'(mem['h124]), 64'h0);
        rst_n = 1'b1;
        wait_n = 0;
        run(1'b0, cyc);
        chk("rerun_acc", 64'(acc), 64'h8);
        chk("rerun_store", 64'(mem['h124]), 64'h8);

        for (int r = 0; r < 20; r++) begin
            clear_mem();
            for (int i = 0; i < 10; i++) begin
                op = int'($urandom_range(0, 15));
                if (op > 12 && $urandom_range(0, 3) != 0) op = int'($urandom_range(0, 12));
                x = int'($urandom_range(0, 'hFFF));
                if (op < 4) x = 'h200 + int'($urandom_range(0, 15));
                if (op == 6 && i == 9) op = 4;
                if (op == 6) x = 'h100 + 2 * int'($urandom_range(i + 1, 9));
                poke('h100 + 2 * i, (op << 12) | x);
            end
            for (int i = 10; i < 14; i++) poke('h100 + 2 * i, 'h4000);
            for (int i = 0; i < 16; i++) poke('h200 + i, int'($urandom_range(0, 'hFFFF)));
            wait_n = int'($urandom_range(0, 2));
            do_reset();
            model(wait_n, e_acc, e_c, e_pc, e_ill, e_cyc);
            run(1'b1, cyc);
            chk($sformatf("rnd%0d_acc", r), 64'(acc), 64'(e_acc));
            chk($sformatf("rnd%0d_carry", r), 64'(carry), 64'(e_c));
            chk($sformatf("rnd%0d_pc", r), 64'(pc), 64'(e_pc));
            chk($sformatf("rnd%0d_illegal", r), 64'(illegal), 64'(e_ill));
            chk($sformatf("rnd%0d_cycles", r), 64'(cyc), 64'(e_cyc));
            bad = 0;
            for (int i = 0; i < 16; i++) if (mem['h200 + i] !== rm['h200 + i]) bad++;
            chk($sformatf("rnd%0d_data_words_wrong", r), 64'(bad), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
